regfile_writer: RTL



---
 rtl/regfile_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_writer.sv
// PS/2 make-code writer for the character register file: strips F0/E0 sequences and sweeps zeros on Enter.
// Optional feature macro: KEY_BACKSPACE_EN (0x66 erases the last stored character).
module regfile_writer #(
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rxData,
  input  logic              rxValid,
  output logic [7:0]        writeData,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddress,
  output logic [ADDR_W-1:0] count,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, CLR} state_t;

  localparam logic [7:0]        BREAK_CODE = 8'hF0;
  localparam logic [7:0]        EXT_CODE   = 8'hE0;
  localparam logic [7:0]        ENTER_CODE = 8'h5A;
  localparam logic [ADDR_W-1:0] ZERO_SLOT  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_SLOT   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_SLOT  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FULL_COUNT = ADDR_W'(DEPTH);

  state_t             stateR, nextStateS;
  logic [ADDR_W-1:0]  ptrR, ptrS;
  logic [ADDR_W-1:0]  countR, countS;
  logic [ADDR_W-1:0]  sweepR, sweepS;
  logic [7:0]         dataR, dataS;
  logic [ADDR_W-1:0]  addrR, addrS;
  logic               weR, weS;
  logic               busyR, busyS;

  // Next-state and next-output decode for the scan-code FSM.
  always_comb begin
    nextStateS = stateR;
    ptrS       = ptrR;
    countS     = countR;
    sweepS     = sweepR;
    dataS      = dataR;
    addrS      = addrR;
    weS        = 1'b0;
    busyS      = busyR;
    case (stateR)
      IDLE: begin
        if (rxValid) begin
          if (rxData == BREAK_CODE) begin
            nextStateS = BRK;
          end else if (rxData == EXT_CODE) begin
            nextStateS = EXT;
          end else if (rxData == ENTER_CODE) begin
            // First sweep write (slot 0) is issued right away so it lands the next cycle.
            nextStateS = CLR;
            busyS      = 1'b1;
            weS        = 1'b1;
            addrS      = ZERO_SLOT;
            dataS      = 8'h00;
            sweepS     = ONE_SLOT;
`ifdef KEY_BACKSPACE_EN
          end else if (rxData == 8'h66) begin
            if (countR != ZERO_SLOT) begin
              ptrS   = (ptrR == ZERO_SLOT) ? LAST_SLOT : ptrR - ONE_SLOT;
              weS    = 1'b1;
              addrS  = ptrS;
              dataS  = 8'h00;
              countS = countR - ONE_SLOT;
            end else begin
              nextStateS = IDLE;
            end
`endif
          end else begin
            weS    = 1'b1;
            addrS  = ptrR;
            dataS  = rxData;
            ptrS   = (ptrR == LAST_SLOT) ? ZERO_SLOT : ptrR + ONE_SLOT;
            countS = (countR == FULL_COUNT) ? countR : countR + ONE_SLOT;
          end
        end else begin
          nextStateS = IDLE;
        end
      end
      BRK: begin
        if (rxValid) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = BRK;
        end
      end
      EXT: begin
        if (rxValid) begin
          nextStateS = (rxData == BREAK_CODE) ? EXT_BRK : IDLE;
        end else begin
          nextStateS = EXT;
        end
      end
      EXT_BRK: begin
        if (rxValid) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = EXT_BRK;
        end
      end
      CLR: begin
        if (sweepR == FULL_COUNT) begin
          nextStateS = IDLE;
          busyS      = 1'b0;
          ptrS       = ZERO_SLOT;
          countS     = ZERO_SLOT;
          sweepS     = ZERO_SLOT;
        end else begin
          weS    = 1'b1;
          addrS  = sweepR;
          dataS  = 8'h00;
          sweepS = sweepR + ONE_SLOT;
        end
      end
      default: begin
        nextStateS = IDLE;
        busyS      = 1'b0;
        sweepS     = ZERO_SLOT;
      end
    endcase
  end

  // State, pointer and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateR <= IDLE;
      ptrR   <= {ADDR_W{1'b0}};
      countR <= {ADDR_W{1'b0}};
      sweepR <= {ADDR_W{1'b0}};
      dataR  <= 8'h00;
      addrR  <= {ADDR_W{1'b0}};
      weR    <= 1'b0;
      busyR  <= 1'b0;
    end else begin
      stateR <= nextStateS;
      ptrR   <= ptrS;
      countR <= countS;
      sweepR <= sweepS;
      dataR  <= dataS;
      addrR  <= addrS;
      weR    <= weS;
      busyR  <= busyS;
    end
  end

  assign writeData    = dataR;
  assign writeEnable  = weR;
  assign writeAddress = addrR;
  assign count        = countR;
  assign busy         = busyR;

endmodule
